// File: rtl/reg_file_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads and the write bypass are combinational. Writes and busy updates happen on the rising clock edge.
module reg_file_sb #(
    parameter int REG_WIDTH = 64,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    input  logic                        flush,
    output logic [REG_COUNT-1:0]        busy_vec
);

    generate
        if (NUM_RD < 1) begin : g_bad_rd
            $error("reg_file_sb: NUM_RD must be >= 1");
        end
        if (NUM_WR < 1) begin : g_bad_wr
            $error("reg_file_sb: NUM_WR must be >= 1");
        end
        if (REG_COUNT < 2 || (REG_COUNT & (REG_COUNT - 1)) != 0) begin : g_bad_cnt
            $error("reg_file_sb: REG_COUNT must be a power of two >= 2");
        end
    endgenerate

    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Ports are visited in ascending order, so the highest enabled port wins an address conflict.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0)) begin
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Priority per register is flush, then alloc, then writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < REG_COUNT; i++) begin
            logic wr_hit;
            wr_hit = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(i)) wr_hit = 1'b1;
            end
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (alloc_en && alloc_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // NOTE: the register array is reset along with the busy bits because reads must return 0
    // after reset. This rules out mapping it to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports. The forwarded data and the zero register override the stored state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            logic [AW-1:0]        ra;
            logic [REG_WIDTH-1:0] data;
            logic                 busy;
            ra   = rd_addr[r*AW +: AW];
            data = regs_q[ra];
            busy = busy_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p*AW +: AW] == ra) begin
                        data = wr_data[p*REG_WIDTH +: REG_WIDTH];
                        busy = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0 && ra == '0) || rst) begin
                data = '0;
                busy = 1'b0;
            end
            rd_data[r*REG_WIDTH +: REG_WIDTH] = data;
            rd_busy[r]                        = busy;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb. The main instance uses bypass and two write ports.
// The second instance has no bypass and shares port 0 of the main instance's stimulus.
module tb_reg_file_sb;

    localparam int W  = 64;
    localparam int AW = 5;

    typedef enum int {S_RD_DATA, S_RD_BUSY, S_BUSY_VEC, S_NB_DATA, S_NB_BUSY, S_NB_VEC} sel_e;
    typedef struct {
        sel_e        sel;
        int          idx;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*W-1:0]  wr_data;
    logic [2*AW-1:0] rd_addr;
    logic [2*W-1:0]  rd_data;
    logic [1:0]    rd_busy;
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;
    logic          flush;
    logic [31:0]   busy_vec;
    logic [W-1:0]  nb_rd_data;
    logic          nb_rd_busy;
    logic [31:0]   nb_busy_vec;

    exp_t exp_q[$];
    event chk_ev;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.REG_WIDTH(W), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2),
                  .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(busy_vec)
    );

    reg_file_sb #(.REG_WIDTH(W), .REG_COUNT(32), .NUM_RD(1), .NUM_WR(1),
                  .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst),
        .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]), .wr_data(wr_data[W-1:0]),
        .rd_addr(rd_addr[AW-1:0]), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(nb_busy_vec)
    );

    function automatic logic [63:0] actual(sel_e sel, int idx);
        case (sel)
            S_RD_DATA:  return rd_data[idx*W +: W];
            S_RD_BUSY:  return {63'b0, rd_busy[idx]};
            S_BUSY_VEC: return {32'b0, busy_vec};
            S_NB_DATA:  return nb_rd_data;
            S_NB_BUSY:  return {63'b0, nb_rd_busy};
            default:    return {32'b0, nb_busy_vec};
        endcase
    endfunction

    // Monitor: pops expectations whenever the stimulus marks a sample point.
    initial begin
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [63:0] act;
                e   = exp_q.pop_front();
                act = actual(e.sel, e.idx);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expect_v(sel_e sel, int idx, logic [63:0] v, string name);
        exp_t e;
        e.sel = sel; e.idx = idx; e.exp = v; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        -> chk_ev;
        #0;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic wr(int p, int a, logic [63:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*W +: W] = d;
    endtask

    task automatic rd(int r, int a);
        rd_addr[r*AW +: AW] = AW'(a);
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0;

        // Reset held: a pending write is neither forwarded nor stored.
        step(); wr(0, 5, 64'hFF); rd(0, 5); #1;
        expect_v(S_RD_DATA, 0, 64'h0, "rst_rd_data");
        expect_v(S_RD_BUSY, 0, 64'h0, "rst_rd_busy");
        expect_v(S_BUSY_VEC, 0, 64'h0, "rst_busy_vec");
        sample();
        @(negedge clk); rst = 1'b0;

        // x0 ignores both the write and the alloc.
        step(); wr(0, 0, 64'hDEAD); alloc_en = 1'b1; alloc_addr = 5'd0; rd(0, 0); #1;
        expect_v(S_RD_DATA, 0, 64'h0, "x0_same_cycle");
        sample();
        step(); rd(0, 0); #1;
        expect_v(S_RD_DATA, 0, 64'h0, "x0_stored");
        expect_v(S_BUSY_VEC, 0, 64'h0, "x0_not_busy");
        sample();

        // Basic write, with and without bypass.
        step(); wr(0, 3, 64'h1234); rd(0, 3); rd(1, 3); #1;
        expect_v(S_RD_DATA, 0, 64'h1234, "x3_bypass_p0");
        expect_v(S_RD_DATA, 1, 64'h1234, "x3_bypass_p1");
        expect_v(S_NB_DATA, 0, 64'h0, "x3_nobypass_old");
        sample();
        step(); rd(0, 3); rd(1, 3); #1;
        expect_v(S_RD_DATA, 0, 64'h1234, "x3_read_p0");
        expect_v(S_RD_DATA, 1, 64'h1234, "x3_read_p1");
        expect_v(S_NB_DATA, 0, 64'h1234, "x3_nobypass_new");
        sample();

        // Write-port conflict: the higher port wins.
        step(); wr(0, 7, 64'hAA); wr(1, 7, 64'hBB); rd(0, 7); #1;
        expect_v(S_RD_DATA, 0, 64'hBB, "x7_conflict_bypass");
        expect_v(S_NB_DATA, 0, 64'h0, "x7_nobypass_old");
        sample();
        step(); rd(0, 7); #1;
        expect_v(S_RD_DATA, 0, 64'hBB, "x7_conflict_stored");
        expect_v(S_NB_DATA, 0, 64'hAA, "x7_nobypass_port0");
        sample();

        // Scoreboard: alloc, then writeback.
        step(); alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 9); #1;
        expect_v(S_RD_BUSY, 0, 64'h0, "x9_alloc_not_yet");
        sample();
        step(); rd(0, 9); #1;
        expect_v(S_RD_BUSY, 0, 64'h1, "x9_busy");
        expect_v(S_BUSY_VEC, 0, 64'h200, "x9_busy_vec");
        expect_v(S_NB_BUSY, 0, 64'h1, "x9_nb_busy");
        expect_v(S_NB_VEC, 0, 64'h200, "x9_nb_busy_vec");
        sample();
        step(); wr(0, 9, 64'h55); rd(0, 9); #1;
        expect_v(S_RD_BUSY, 0, 64'h0, "x9_wb_busy_bypass");
        expect_v(S_RD_DATA, 0, 64'h55, "x9_wb_data_bypass");
        expect_v(S_NB_BUSY, 0, 64'h1, "x9_wb_nb_busy");
        sample();
        step(); rd(0, 9); #1;
        expect_v(S_BUSY_VEC, 0, 64'h0, "x9_cleared");
        expect_v(S_RD_DATA, 0, 64'h55, "x9_stored");
        expect_v(S_NB_BUSY, 0, 64'h0, "x9_nb_cleared");
        sample();

        // Alloc beats a same-cycle writeback. Flush beats alloc.
        step(); alloc_en = 1'b1; alloc_addr = 5'd4; wr(1, 4, 64'h4444); rd(1, 4); #1;
        sample();
        step(); rd(1, 4); #1;
        expect_v(S_BUSY_VEC, 0, 64'h10, "x4_alloc_wins");
        expect_v(S_RD_DATA, 1, 64'h4444, "x4_data");
        expect_v(S_RD_BUSY, 1, 64'h1, "x4_rd_busy");
        sample();
        step(); alloc_en = 1'b1; alloc_addr = 5'd10; flush = 1'b1; #1;
        sample();
        step(); #1;
        expect_v(S_BUSY_VEC, 0, 64'h0, "flush_wins");
        sample();

        // Asynchronous reset between clock edges.
        step(); wr(0, 2, 64'h77);
        step(); alloc_en = 1'b1; alloc_addr = 5'd2;
        step(); alloc_en = 1'b1; alloc_addr = 5'd4;
        step(); rd(0, 2); #1;
        expect_v(S_BUSY_VEC, 0, 64'h14, "pre_rst_busy");
        expect_v(S_RD_DATA, 0, 64'h77, "pre_rst_x2");
        sample();
        #1 rst = 1'b1;
        #1;
        expect_v(S_BUSY_VEC, 0, 64'h0, "async_rst_busy");
        expect_v(S_RD_DATA, 0, 64'h0, "async_rst_x2");
        sample();
        #1 rst = 1'b0;
        step(); rd(0, 2); #1;
        expect_v(S_RD_DATA, 0, 64'h0, "post_rst_x2");
        expect_v(S_BUSY_VEC, 0, 64'h0, "post_rst_busy");
        sample();
        step(); wr(0, 2, 64'h88); rd(0, 3); #1;
        expect_v(S_RD_DATA, 0, 64'h0, "post_rst_x3");
        sample();
        step(); rd(0, 2); #1;
        expect_v(S_RD_DATA, 0, 64'h88, "post_rst_write");
        sample();

        #1;
        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port integer register file with a built-in scoreboard, for the five-stage pipeline and wider-issue variants.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Write-to-read bypass is selectable, and register x0 can be made hardwired to zero.
- A per-register busy bit is set when a producer issues and cleared on writeback, so issue logic can detect RAW hazards without a separate scoreboard block.

Parameters:
REG_WIDTH, 64, data width of each register.
REG_COUNT, 32, number of registers (power of two, >=2); AW = $clog2(REG_COUNT).
NUM_RD, 2, number of read ports (>=1).
NUM_WR, 1, number of write ports (>=1).
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never busy.
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads and busy is suppressed.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, port p at [p*AW +: AW]
wr_data  in  NUM_WR*REG_WIDTH  write data, port p at [p*REG_WIDTH +: REG_WIDTH]
rd_addr  in  NUM_RD*AW  read addresses, packed the same way
rd_data  out  NUM_RD*REG_WIDTH  read data
rd_busy  out  NUM_RD  1 = addressed register has an outstanding producer
alloc_en  in  1  mark alloc_addr busy (destination issued)
alloc_addr  in  AW  register to mark busy
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  REG_COUNT  registered busy bits

Behaviour:
- Reset (async, rst=1): all registers = 0; busy_vec = 0. rd_data reads 0 for any address and rd_busy = 0 while rst is held.
- Write, registered:
  - On posedge clk, for each port p with wr_en[p]=1, reg[wr_addr_p] <= wr_data_p.
  - If ZERO_REG=1 and wr_addr_p==0, the write is dropped.
  - Several enabled ports targeting the same address: the highest port index wins.
- Read, combinational, zero latency:
  - rd_data_r = reg[rd_addr_r].
  - If ZERO_REG=1 and rd_addr_r==0, rd_data_r = 0 regardless of writes.
  - If BYPASS=1 and some enabled port writes rd_addr_r this cycle, rd_data_r = that port's wr_data. If several match, the highest index wins, consistent with the stored value after the edge.
- Busy, next-state per register i, evaluated on posedge clk:
  - flush=1: busy[i] <= 0. Flush overrides alloc in the same cycle.
  - else alloc_en=1 and alloc_addr==i: busy[i] <= 1. Alloc beats a simultaneous write to i, because the new producer supersedes the old one.
  - else any wr_en[p] with wr_addr_p==i: busy[i] <= 0.
  - else hold.
  - ZERO_REG=1: busy[0] is constant 0, and alloc to 0 is ignored.
- rd_busy:
  - rd_busy_r = busy[rd_addr_r].
  - If BYPASS=1 and a matching write is enabled this cycle, rd_busy_r = 0, because the data is forwarded.
  - Same-cycle alloc does not affect rd_busy; it becomes visible next cycle.
- Writes do not depend on busy state. A write to a non-busy register is legal, updates the data, and leaves busy at 0.
- Reset asserted mid-operation: everything clears immediately, and the pending write on that edge is lost. On rst release the block operates normally from the next edge.
- Out-of-range addresses cannot occur because REG_COUNT is a power of two.
- Parameter-checked at elaboration: NUM_RD>=1, NUM_WR>=1, REG_COUNT power of two.

Test Plan:
- Reset / zero register: hold rst, read addr 5 -> rd_data=0, rd_busy=0. Release rst, write 0xDEAD to x0 -> read x0 = 0, busy_vec[0]=0.
- Basic write/read: write x3=0x1234 via port 0, then read x3 on both read ports next cycle -> 0x1234 on each. With BYPASS=1, the same-cycle read of x3 also returns 0x1234. With BYPASS=0, the same-cycle read returns the old value 0.
- Multi-write conflict (NUM_WR=2): both ports write x7 in one cycle (0xAA on port 0, 0xBB on port 1) -> same-cycle bypass read = 0xBB, and the stored value = 0xBB.
- Scoreboard: alloc x9 -> next cycle rd_busy=1 for x9 and busy_vec[9]=1. Write x9=0x55 -> same-cycle rd_busy=0 (BYPASS=1), and busy_vec[9]=0 after the edge.
- Alloc vs writeback, then flush:
  - Alloc x4 and write x4 in the same cycle -> busy_vec[4]=1 after the edge, data=new value.
  - Then alloc x10 together with flush=1 -> busy_vec = 0.
- Async reset mid-stream: busy x2 and x4 set, x2=0x77 stored; pulse rst between clock edges -> busy_vec=0 and x2 reads 0 immediately, without waiting for a clock edge.
